// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// Parametrised SPI data-path shifter. The SPI control FSM supplies SCLK edge
// strobes plus start/abort; the received word and its valid pulse go to the
// APB register file.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; mosi holds its last bit, events ignored
// ST_ACTIVE | shifting; sample/shift events act on the latched config
// ST_DONE   | one cycle; rx_valid high, start may launch the next transfer

module spi_shift_engine #(
    parameter int MAX_WIDTH = 16,
    parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     xfer_len,
    input  logic                 lsbfe,
    input  logic                 cpha,
    input  logic                 cpol,
    input  logic                 posedge_sclk_event,
    input  logic                 negedge_sclk_event,
    input  logic                 miso,
    input  logic [MAX_WIDTH-1:0] tx_data,
    output logic                 mosi,
    output logic [MAX_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LP_MAX_LEN = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [MAX_WIDTH-1:0] r_tx;
    logic [MAX_WIDTH-1:0] r_rx;
    logic [MAX_WIDTH-1:0] r_rx_data;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_lsbfe;
    logic                 r_cpha;
    logic                 r_cpol;
    logic                 r_mosi;

    logic [CNT_W-1:0]     w_len_in;
    logic [CNT_W-1:0]     w_bit_idx;
    logic                 w_lead;
    logic                 w_trail;
    logic                 w_sample_ev;
    logic                 w_shift_ev;
    logic                 w_active;
    logic                 w_do_sample;
    logic                 w_do_shift;
    logic                 w_finish;
    logic                 w_launch;
    logic                 w_first_bit;

    // Variable bit select kept as a compare loop so the index width never
    // has to match the word width exactly.
    function automatic logic f_bit(input logic [MAX_WIDTH-1:0] v,
                                   input logic [CNT_W-1:0]     idx);
        f_bit = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (CNT_W'(i) == idx) f_bit = v[i];
        end
    endfunction

    // Zero or oversize lengths fall back to a full-width transfer.
    assign w_len_in = ((xfer_len == '0) || (xfer_len > LP_MAX_LEN)) ? LP_MAX_LEN : xfer_len;

    assign w_lead      = r_cpol ? negedge_sclk_event : posedge_sclk_event;
    assign w_trail     = r_cpol ? posedge_sclk_event : negedge_sclk_event;
    assign w_sample_ev = r_cpha ? w_trail : w_lead;
    assign w_shift_ev  = r_cpha ? w_lead  : w_trail;

    // Bit k of the transfer: same position for the outgoing and incoming word.
    assign w_bit_idx   = r_lsbfe ? r_cnt : (r_len - LP_ONE - r_cnt);

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_do_sample = w_active & w_sample_ev & (r_cnt < r_len);
    // A coincident sample wins; a shift at count 0 or len would repeat or overrun.
    assign w_do_shift  = w_active & w_shift_ev & ~w_sample_ev & (r_cnt != '0) & (r_cnt < r_len);
    assign w_finish    = w_active & (r_cnt == r_len);
    assign w_launch    = start & ~abort & (r_state != ST_ACTIVE);
    assign w_first_bit = lsbfe ? tx_data[0] : f_bit(tx_data, w_len_in - LP_ONE);

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start)    w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (w_finish) w_state_nxt = ST_DONE;
                ST_DONE:   w_state_nxt = start ? ST_ACTIVE : ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Config latch, bit counter, serial in/out and result register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_lsbfe   <= 1'b0;
            r_cpha    <= 1'b0;
            r_cpol    <= 1'b0;
            r_mosi    <= 1'b0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (w_launch) begin
            r_tx    <= tx_data;
            r_len   <= w_len_in;
            r_lsbfe <= lsbfe;
            r_cpha  <= cpha;
            r_cpol  <= cpol;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_mosi  <= w_first_bit;
        end else begin
            if (w_do_sample) begin
                for (int i = 0; i < MAX_WIDTH; i++) begin
                    if (CNT_W'(i) == w_bit_idx) r_rx[i] <= miso;
                end
                r_cnt <= r_cnt + LP_ONE;
            end
            if (w_do_shift) r_mosi <= f_bit(r_tx, w_bit_idx);
            if (w_finish)   r_rx_data <= r_rx;
        end
    end

    assign mosi     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = (r_state == ST_DONE);
    assign busy     = w_active;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: SPI edge streams against a bit-level model of
// what a 16-bit SPI shifter must put on mosi and deliver as rx_data.
module tb_spi_shift_engine;

    localparam int MW = 16;
    localparam int CW = 5;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] xfer_len = '0;
    logic          lsbfe = 1'b0;
    logic          cpha = 1'b0;
    logic          cpol = 1'b0;
    logic          posedge_sclk_event = 1'b0;
    logic          negedge_sclk_event = 1'b0;
    logic          miso = 1'b0;
    logic [MW-1:0] tx_data = '0;
    logic          mosi;
    logic [MW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          mon_cyc[$];
    logic [15:0] mon_data[$];
    int          exp_cyc[$];
    logic [15:0] exp_data[$];

    spi_shift_engine #(.MAX_WIDTH(MW)) dut (
        .PCLK               (PCLK),
        .PRESETn            (PRESETn),
        .start              (start),
        .abort              (abort),
        .xfer_len           (xfer_len),
        .lsbfe              (lsbfe),
        .cpha               (cpha),
        .cpol               (cpol),
        .posedge_sclk_event (posedge_sclk_event),
        .negedge_sclk_event (negedge_sclk_event),
        .miso               (miso),
        .tx_data            (tx_data),
        .mosi               (mosi),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .busy               (busy)
    );

    always #5 PCLK = ~PCLK;

    // Cycle stamp and rx_valid log, taken mid-cycle.
    always @(negedge PCLK) begin
        cyc = cyc + 1;
        if (rx_valid === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_data.push_back(rx_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One SPI transfer: start pulse, then L leading/trailing edge pairs with
    // random gaps. mosi is checked at each sampling edge against the bit an SPI
    // slave would read; the expected rx_valid cycle and word are queued.
    task automatic run_xfer(input logic [15:0] tx, input logic [4:0] len_in,
                            input logic lsb, input logic ph, input logic pl,
                            input logic [15:0] rxw, input bit chain, input bit disturb);
        int          L;
        int          c_s;
        bit          last;
        logic [15:0] mask;
        logic        exp_bit;
        L = (len_in == 5'd0 || len_in > 5'd16) ? 16 : int'(len_in);
        mask = (L == 16) ? 16'hFFFF : 16'((32'd1 << L) - 1);
        last = 1'b0;
        c_s  = 0;
        tx_data = tx; xfer_len = len_in; lsbfe = lsb; cpha = ph; cpol = pl; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int k = 0; k < L && !(chain && last); k++) begin
            for (int e = 0; e < 2 && !(chain && last); e++) begin
                bit is_s;
                bit pos_edge;
                is_s     = (e == (ph ? 1 : 0));
                pos_edge = (e == 0) ? ~pl : pl;
                if (is_s) begin
                    exp_bit = lsb ? tx[k] : tx[L-1-k];
                    total++;
                    if (mosi !== exp_bit) begin
                        bad++;
                        $display("FAIL mosi_bit%0d (tx=%h len=%0d lsb=%b cpha=%b cpol=%b): got %b want %b",
                                 k, tx, L, lsb, ph, pl, mosi, exp_bit);
                    end
                    total++;
                    if (busy !== 1'b1) begin
                        bad++;
                        $display("FAIL busy_during_bit%0d: got %b want 1", k, busy);
                    end
                    miso = lsb ? rxw[k] : rxw[L-1-k];
                end else begin
                    miso = 1'($urandom_range(0, 1));
                end
                if (pos_edge) posedge_sclk_event = 1'b1;
                else          negedge_sclk_event = 1'b1;
                if (is_s && $urandom_range(0, 3) == 0) begin
                    posedge_sclk_event = 1'b1;
                    negedge_sclk_event = 1'b1;
                end
                tick();
                posedge_sclk_event = 1'b0;
                negedge_sclk_event = 1'b0;
                if (is_s && k == L - 1) begin
                    c_s = cyc;
                    exp_cyc.push_back(c_s + 2);
                    exp_data.push_back(rxw & mask);
                    last = 1'b1;
                end
                if (chain && last) begin
                    tick();
                end else begin
                    if (disturb && !last) begin
                        tx_data  = 16'($urandom);
                        xfer_len = 5'($urandom_range(0, 31));
                        lsbfe    = 1'($urandom_range(0, 1));
                        cpha     = 1'($urandom_range(0, 1));
                        cpol     = 1'($urandom_range(0, 1));
                        start    = ($urandom_range(0, 2) == 0);
                        tick();
                        start = 1'b0;
                    end
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        end
        if (!chain) begin
            while (cyc < c_s + 4) tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_after_done: got %b want 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        #12;
        total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_idle_events();
        for (int i = 0; i < 10; i++) begin
            posedge_sclk_event = 1'($urandom_range(0, 1));
            negedge_sclk_event = 1'($urandom_range(0, 1));
            miso = 1'($urandom_range(0, 1));
            tick();
        end
        posedge_sclk_event = 1'b0;
        negedge_sclk_event = 1'b0;
        tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        total++; if (mosi !== 1'b0)      begin bad++; $display("FAIL idle_mosi: got %b want 0", mosi); end
        total++; if (rx_data !== 16'h0)  begin bad++; $display("FAIL idle_rx_data: got %h want 0000", rx_data); end
        total++; if (mon_cyc.size() != 0) begin bad++; $display("FAIL idle_rx_valid_count: got %0d want 0", mon_cyc.size()); end
        mon_cyc.delete(); mon_data.delete();
    endtask

    task automatic test_msb_mode0();
        run_xfer(16'h00A5, 5'd8, 1'b0, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0);
        total++; if (rx_data !== 16'h003C) begin bad++; $display("FAIL msb_mode0_rx_data: got %h want 003c", rx_data); end
        total++;
        if (mon_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL msb_mode0_valid_count: got %0d want %0d", mon_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL msb_mode0_latency: got cycle %0d want %0d", mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL msb_mode0_data: got %h want %h", mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    task automatic test_lsb_mode3();
        run_xfer(16'h0ABC, 5'd12, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
        total++;
        if (mon_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL lsb_mode3_valid_count: got %0d want %0d", mon_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL lsb_mode3_latency: got cycle %0d want %0d", mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL lsb_mode3_data: got %h want %h", mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    task automatic test_len_clamp();
        run_xfer(16'hFFFF, 5'd0,  1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0);
        run_xfer(16'hFFFF, 5'd20, 1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        total++;
        if (mon_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL len_clamp_valid_count: got %0d want %0d", mon_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL len_clamp_latency: got cycle %0d want %0d", mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL len_clamp_data: got %h want %h", mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    task automatic test_back_to_back();
        run_xfer(16'($urandom), 5'd8, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
        run_xfer(16'h0011, 5'd8, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        total++;
        if (mon_cyc.size() != 2) begin bad++; $display("FAIL b2b_valid_count: got %0d want 2", mon_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL b2b_latency: got cycle %0d want %0d", mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL b2b_data: got %h want %h", mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [4:0] len;
            len = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
            if (n == 0) len = 5'd1;
            run_xfer(16'($urandom), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end
        total++;
        if (mon_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL random_valid_count: got %0d want %0d", mon_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL random_latency[%0d]: got cycle %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    task automatic test_abort();
        logic [15:0] txm;
        txm = 16'hC3A5;
        run_xfer(16'($urandom), 5'd16, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'h1234, 1'b0, 1'b0);
        total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL abort_prior_rx_data: got %h want 1234", rx_data); end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
        tx_data = txm; xfer_len = 5'd16; lsbfe = 1'b0; cpha = 1'b0; cpol = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (mosi !== txm[15-k]) begin bad++; $display("FAIL abort_mosi_bit%0d: got %b want %b", k, mosi, txm[15-k]); end
            posedge_sclk_event = 1'b1;
            miso = 1'($urandom_range(0, 1));
            tick();
            posedge_sclk_event = 1'b0;
            if (k == 2) begin
                start = 1'b1; tx_data = ~txm; lsbfe = 1'b1; xfer_len = 5'd3;
            end
            negedge_sclk_event = 1'b1;
            tick();
            negedge_sclk_event = 1'b0;
            start = 1'b0;
        end
        total++; if (mosi !== txm[10]) begin bad++; $display("FAIL abort_mosi_bit5: got %b want %b", mosi, txm[10]); end
        abort = 1'b1; start = 1'b1; posedge_sclk_event = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; posedge_sclk_event = 1'b0;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (rx_data !== 16'h1234) begin bad++; $display("FAIL abort_rx_data: got %h want 1234", rx_data); end
        total++; if (rx_valid !== 1'b0)    begin bad++; $display("FAIL abort_rx_valid: got %b want 0", rx_valid); end
        repeat (4) tick();
        total++; if (mon_cyc.size() != 0) begin bad++; $display("FAIL abort_valid_count: got %0d want 0", mon_cyc.size()); end
        mon_cyc.delete(); mon_data.delete();
    endtask

    task automatic test_reset_mid();
        tx_data = 16'hFFFF; xfer_len = 5'd16; lsbfe = 1'b0; cpha = 1'b0; cpol = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            posedge_sclk_event = 1'b1; miso = 1'b1;
            tick();
            posedge_sclk_event = 1'b0; negedge_sclk_event = 1'b1;
            tick();
            negedge_sclk_event = 1'b0;
        end
        total++; if (mosi !== 1'b1) begin bad++; $display("FAIL rst_mid_mosi_before: got %b want 1", mosi); end
        #3;
        PRESETn = 1'b0;
        #1;
        total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL rst_mid_mosi: got %b want 0", mosi); end
        total++; if (rx_data !== 16'h0) begin bad++; $display("FAIL rst_mid_rx_data: got %h want 0000", rx_data); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
        total++; if (mon_cyc.size() != 0) begin bad++; $display("FAIL rst_mid_valid_count: got %0d want 0", mon_cyc.size()); end
        mon_cyc.delete(); mon_data.delete();
        run_xfer(16'($urandom), 5'd10, 1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        total++;
        if (mon_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL rst_mid_clean_count: got %0d want %0d", mon_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < mon_cyc.size(); i++) begin
            total++; if (mon_cyc[i] !== exp_cyc[i])   begin bad++; $display("FAIL rst_mid_clean_latency: got cycle %0d want %0d", mon_cyc[i], exp_cyc[i]); end
            total++; if (mon_data[i] !== exp_data[i]) begin bad++; $display("FAIL rst_mid_clean_data: got %h want %h", mon_data[i], exp_data[i]); end
        end
        mon_cyc.delete(); mon_data.delete(); exp_cyc.delete(); exp_data.delete();
    endtask

    initial begin
        test_reset();
        test_idle_events();
        test_msb_mode0();
        test_lsb_mode3();
        test_len_clamp();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
